hw2_alu_arbiter: RTL

Round-robin arbiter that shares the single 2-stage-pipelined HW2_alu between two requesters. Each requester issues operations (A, B, inst) with a valid/ready handshake. The arbiter forwards one granted operation per cycle to the ALU and tracks ownership of every in-flight operation in a tag pipeline. It returns each ALU result to the requester that issued it. The block sits directly in front of HW2_alu; its alu_* outputs drive data_a_i/data_b_i/inst_i, and data_o returns on alu_data_i.

---
 rtl/hw2_alu_arbiter.sv | 91 +++++++++
 1 files changed

// File: rtl/hw2_alu_arbiter.sv
// hw2_alu_arbiter: round-robin share of the 2-stage HW2_alu between two requesters with tagged result return.
// Define HW2_ALU_ARB_ILLEGAL_EN to trap opcode 3'b111 (held ALU inputs, zeroed data, rsp_err_o).
module hw2_alu_arbiter #(
  parameter int ALU_LAT = 2,
  parameter int DW = 8,
  parameter int OW = 16
) (
  input  logic          clk_p_i,
  input  logic          reset_n_i,
  input  logic          req0_valid_i,
  output logic          req0_ready_o,
  input  logic [DW-1:0] req0_a_i,
  input  logic [DW-1:0] req0_b_i,
  input  logic [2:0]    req0_inst_i,
  input  logic          req1_valid_i,
  output logic          req1_ready_o,
  input  logic [DW-1:0] req1_a_i,
  input  logic [DW-1:0] req1_b_i,
  input  logic [2:0]    req1_inst_i,
  output logic [DW-1:0] alu_a_o,
  output logic [DW-1:0] alu_b_o,
  output logic [2:0]    alu_inst_o,
  input  logic [OW-1:0] alu_data_i,
  output logic          rsp0_valid_o,
  output logic          rsp1_valid_o,
  output logic [OW-1:0] rsp_data_o,
`ifdef HW2_ALU_ARB_ILLEGAL_EN
  output logic          rsp_err_o,
`endif
  output logic          busy_o
);
`ifdef HW2_ALU_ARB_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif
  logic          gnt0, gnt1, acc, sel, ill;
  logic          ptr_q, ptr_d;
  logic [DW-1:0] op_a, op_b, a_q, a_d, b_q, b_d;
  logic [2:0]    op_inst, inst_q, inst_d;
  logic [ALU_LAT:0] tv_q, tv_d, tid_q, tid_d, te_q, te_d;
  always_comb begin
    gnt0    = req0_valid_i & (~req1_valid_i | ~ptr_q);
    gnt1    = req1_valid_i & (~req0_valid_i | ptr_q);
    acc     = gnt0 | gnt1;
    sel     = gnt1;
    op_a    = sel ? req1_a_i : req0_a_i;
    op_b    = sel ? req1_b_i : req0_b_i;
    op_inst = sel ? req1_inst_i : req0_inst_i;
    ill     = ILL_EN && acc && (op_inst == 3'b111);
    a_d     = (acc && !ill) ? op_a : a_q;
    b_d     = (acc && !ill) ? op_b : b_q;
    inst_d  = (acc && !ill) ? op_inst : inst_q;
    ptr_d   = acc ? ~sel : ptr_q;
    tv_d    = {tv_q[ALU_LAT-1:0], acc};
    tid_d   = {tid_q[ALU_LAT-1:0], sel};
    te_d    = {te_q[ALU_LAT-1:0], ill};
  end
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_q  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      inst_q <= 3'b000;
      tv_q   <= '0;
      tid_q  <= '0;
      te_q   <= '0;
    end else begin
      ptr_q  <= ptr_d;
      a_q    <= a_d;
      b_q    <= b_d;
      inst_q <= inst_d;
      tv_q   <= tv_d;
      tid_q  <= tid_d;
      te_q   <= te_d;
    end
  end
  assign req0_ready_o = gnt0;
  assign req1_ready_o = gnt1;
  assign alu_a_o      = a_q;
  assign alu_b_o      = b_q;
  assign alu_inst_o   = inst_q;
  assign rsp0_valid_o = tv_q[ALU_LAT] & ~tid_q[ALU_LAT];
  assign rsp1_valid_o = tv_q[ALU_LAT] & tid_q[ALU_LAT];
  // Illegal ops never reached the ALU, so whatever it shows is stale.
  assign rsp_data_o   = te_q[ALU_LAT] ? '0 : alu_data_i;
  assign busy_o       = |tv_q;
`ifdef HW2_ALU_ARB_ILLEGAL_EN
  assign rsp_err_o    = tv_q[ALU_LAT] & te_q[ALU_LAT];
`endif
endmodule
